pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register; successor to the fixed IF/ID and ID/EX latches.
- Carries a DATA_W payload plus a CTRL_W control bundle between two pipeline stages, using a valid/ready handshake.
- Adds synchronous flush-to-bubble, freeze (stall), and an optional 2-entry skid buffer so in_ready is fully registered.
- Instanced once per pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) with per-stage widths.

Parameters:
- DATA_W, 32, payload width (instruction, pc+4, operands, immediates packed by the instantiating stage).
- CTRL_W, 8, control bundle width (EX/MEM/WB control fields).
- BUBBLE_CTRL, 0, value loaded into ctrl fields on flush or reset; must encode a no-op.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous kill of all held entries (branch/jump mispredict).
- freeze, input, 1, synchronous stall: hold all state and block both transfers.
- in_valid, input, 1, upstream has an entry.
- in_ready, output, 1, stage can accept an entry.
- in_data, input, DATA_W, upstream payload.
- in_ctrl, input, CTRL_W, upstream control bundle.
- out_valid, output, 1, out_data/out_ctrl hold a live entry.
- out_ready, input, 1, downstream accepts.
- out_data, output, DATA_W, registered payload.
- out_ctrl, output, CTRL_W, registered control; BUBBLE_CTRL when empty after a flush or reset.
- occupancy, output, 2, number of live entries (0..2; max 1 when SKID=0).

Behaviour:
- Reset (rst_n=0, async): out_valid=0, skid valid=0, out_data=0, out_ctrl=BUBBLE_CTRL, skid data/ctrl=0/BUBBLE_CTRL, occupancy=0. With SKID=1, in_ready=1 after release. Reset is honoured mid-transfer; the entry is discarded.
- Priority, per clock edge: reset > flush > freeze > normal.
- Transfer definitions:
  - in_xfer = in_valid & in_ready & !flush & !freeze.
  - out_xfer = out_valid & out_ready & !freeze.
- Flush:
  - Next state: both valid bits cleared and out_ctrl=BUBBLE_CTRL; out_data holds its value.
  - Any same-cycle input is dropped; flush also overrides freeze.
  - The out_valid=1 in the flush cycle still completes a transfer if out_ready=1; the downstream stage owns that decision.
- Freeze:
  - All registers hold.
  - in_ready is forced to 0 combinationally.
  - out_valid keeps its value, but no out_xfer occurs.
- SKID=1, normal operation:
  - in_ready = !skid_valid & !freeze; skid_valid is a register.
  - Main-register load happens when !out_valid | out_xfer. It loads from the skid if skid_valid, else from the input if in_xfer, else out_valid goes to 0.
  - Skid capture: in_xfer while the main register is full and not draining (out_valid & !out_xfer), or in_xfer in the same cycle the main register loads from the skid.
  - Ordering is FIFO; the skid entry always leaves before the newer input.
- SKID=0, normal operation:
  - in_ready = (!out_valid | out_ready) & !freeze, combinational.
  - The main register loads on in_xfer and clears out_valid on out_xfer with no in_xfer.
- Throughput and latency:
  - One entry per cycle under continuous in_valid/out_ready.
  - Latency is 1 cycle, in_xfer to out_valid.
- occupancy = out_valid + skid_valid. It never exceeds 2; a third entry is impossible because in_ready=0 whenever the skid is full.
- Empty stage: out_ctrl must equal BUBBLE_CTRL whenever out_valid=0, so downstream never sees stale control.

Decomposition:
- Shared package pipe_pkg holds:
  - Per-boundary width constants: IF_ID_DATA_W=64, ID_EX_CTRL_W, and so on.
  - The BUBBLE_CTRL encodings.
  - The packed ctrl field layouts (EX/MEM/WB).
- One sub-module is natural: pipe_entry_reg, a single data+ctrl+valid register with load/clear enables. Instance it once for the main register and once for the skid (skid instance generated only when SKID=1).

Test Plan:
- Streaming: SKID=1, in_valid=1, out_ready=1, in_data=0,1,2,... for 10 cycles -> out_data 0..9 one cycle later, in_ready=1 throughout, occupancy=1.
- Backpressure: send A=0x11, B=0x22, then drop out_ready for 3 cycles while in_valid stays high -> B lands in the skid, in_ready=0 and occupancy=2. Raise out_ready -> outputs 0x11, 0x22, then the next input, in order with no loss or duplication.
- Flush: occupancy=2 with ctrl=0x5A, assert flush with in_valid=1 -> next cycle out_valid=0, occupancy=0, out_ctrl=BUBBLE_CTRL, in_ready=1, and the flush-cycle input never appears.
- Freeze: out_valid=1 with data 0x33, freeze=1 for 4 cycles with out_ready=1 -> in_ready=0 and outputs stable. Deassert -> 0x33 transfers exactly once.
- Simultaneous flush+freeze: flush wins, so the stage is empty next cycle. Async reset asserted mid-stream with rst_n low for half a cycle -> outputs return to reset values immediately, without waiting for a clock edge.
- SKID=0 build: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. out_ready=1 -> in_ready=1 and new data is accepted with 1-cycle latency.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: per-boundary widths, packed control layouts and bubble encodings.
package pipe_pkg;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
  } mem_ctrl_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
  } ex_ctrl_t;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } id_ex_ctrl_t;

  typedef struct packed {
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ex_mem_ctrl_t;

  typedef wb_ctrl_t mem_wb_ctrl_t;

  // IF/ID carries instruction + pc+4; ID/EX carries pc+4, two operands and the immediate
  localparam int IF_ID_DATA_W  = 64;
  localparam int IF_ID_CTRL_W  = 1;
  localparam int ID_EX_DATA_W  = 128;
  localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
  localparam int EX_MEM_DATA_W = 96;
  localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
  localparam int MEM_WB_DATA_W = 64;
  localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

  // All-zero control never writes a register or touches memory, so it is a safe no-op
  localparam logic [IF_ID_CTRL_W-1:0] IF_ID_BUBBLE  = '0;
  localparam id_ex_ctrl_t             ID_EX_BUBBLE  = '0;
  localparam ex_mem_ctrl_t            EX_MEM_BUBBLE = '0;
  localparam mem_wb_ctrl_t            MEM_WB_BUBBLE = '0;

  typedef enum logic [1:0] {
    SRC_HOLD,
    SRC_SKID,
    SRC_INPUT,
    SRC_CLEAR
  } load_src_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid bit, payload and control with load and clear enables.
module pipe_entry_reg #(
  parameter int                DATA_W      = 32,
  parameter int                CTRL_W      = 8,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  // Clear beats load; clearing keeps the payload but forces control back to the no-op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_ctrl  <= BUBBLE_CTRL;
    end else if (clear) begin
      q_valid <= 1'b0;
      q_ctrl  <= BUBBLE_CTRL;
    end else if (load) begin
      q_valid <= 1'b1;
      q_data  <= d_data;
      q_ctrl  <= d_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline stage register with flush, freeze and optional skid entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                CTRL_W      = 8,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter bit                SKID        = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              in_xfer;
  logic              out_xfer;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  load_src_e         main_src;
  logic              main_load;
  logic              main_clear;
  logic [DATA_W-1:0] main_d_data;
  logic [CTRL_W-1:0] main_d_ctrl;

  assign in_xfer  = in_valid & in_ready & ~flush & ~freeze;
  assign out_xfer = out_valid & out_ready & ~freeze;

  generate
    if (SKID) begin : g_skid
      logic main_open;
      logic skid_load;
      logic skid_clear;

      assign in_ready = ~skid_valid & ~freeze;

      // The skid entry is older than any new input, so it always refills the main register first
      always_comb begin
        main_src   = SRC_HOLD;
        main_open  = (~out_valid | out_xfer) & ~flush & ~freeze;
        skid_load  = in_xfer & ((out_valid & ~out_xfer) | (main_open & skid_valid));
        skid_clear = flush | (main_open & skid_valid & ~skid_load);
        if (flush) begin
          main_src = SRC_CLEAR;
        end else if (main_open) begin
          if (skid_valid)   main_src = SRC_SKID;
          else if (in_xfer) main_src = SRC_INPUT;
          else              main_src = SRC_CLEAR;
        end
      end

      pipe_entry_reg #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .BUBBLE_CTRL (BUBBLE_CTRL)
      ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (skid_load),
        .clear   (skid_clear),
        .d_data  (in_data),
        .d_ctrl  (in_ctrl),
        .q_valid (skid_valid),
        .q_data  (skid_data),
        .q_ctrl  (skid_ctrl)
      );
    end else begin : g_no_skid
      assign in_ready   = (~out_valid | out_ready) & ~freeze;
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = BUBBLE_CTRL;

      always_comb begin
        main_src = SRC_HOLD;
        if (flush)         main_src = SRC_CLEAR;
        else if (in_xfer)  main_src = SRC_INPUT;
        else if (out_xfer) main_src = SRC_CLEAR;
      end
    end
  endgenerate

  always_comb begin
    main_load   = (main_src == SRC_SKID) | (main_src == SRC_INPUT);
    main_clear  = (main_src == SRC_CLEAR);
    main_d_data = in_data;
    main_d_ctrl = in_ctrl;
    if (main_src == SRC_SKID) begin
      main_d_data = skid_data;
      main_d_ctrl = skid_ctrl;
    end
  end

  pipe_entry_reg #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .BUBBLE_CTRL (BUBBLE_CTRL)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (main_load),
    .clear   (main_clear),
    .d_data  (main_d_data),
    .d_ctrl  (main_d_ctrl),
    .q_valid (out_valid),
    .q_data  (out_data),
    .q_ctrl  (out_ctrl)
  );

  assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a skid and a non-skid build with shared stimulus and checks both against FIFO scoreboards.
module tb_pipe_stage_reg;

  localparam int             DW  = 32;
  localparam int             CW  = 8;
  localparam logic [CW-1:0]  BUB = 8'hC3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          freeze = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;

  logic          ir1, ov1, ir0, ov0;
  logic [DW-1:0] od1, od0;
  logic [CW-1:0] oc1, oc0;
  logic [1:0]    occ1, occ0;

  entry_t sb1[$];
  entry_t sb0[$];
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .SKID(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ctrl(oc1),
    .occupancy(occ1)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .SKID(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(ir0), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ctrl(oc0),
    .occupancy(occ0)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkStage(input string tag, input int n, input entry_t head, input logic ir_exp,
                            input logic ir, input logic ov, input logic [1:0] occ,
                            input logic [DW-1:0] od, input logic [CW-1:0] oc);
    checkOutput({tag, ".in_ready"}, ir, ir_exp);
    checkOutput({tag, ".out_valid"}, ov, n > 0);
    checkOutput({tag, ".occupancy"}, occ, n);
    if (n > 0) begin
      checkOutput({tag, ".out_data"}, od, head.data);
      checkOutput({tag, ".out_ctrl"}, oc, head.ctrl);
    end else begin
      checkOutput({tag, ".bubble_ctrl"}, oc, BUB);
    end
  endtask

  // One cycle: drive at the falling edge, check just after, then advance both models at the rising edge
  task automatic applyStimulus(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                               input logic ordy, input logic fl, input logic fz);
    entry_t e, h1, h0;
    logic   ir1_exp, ir0_exp, in1, out1, in0, out0;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    freeze    = fz;
    #1;
    ir1_exp = (sb1.size() < 2) && !fz;
    ir0_exp = ((sb0.size() == 0) || ordy) && !fz;
    h1 = (sb1.size() > 0) ? sb1[0] : '0;
    h0 = (sb0.size() > 0) ? sb0[0] : '0;
    checkStage("skid1", sb1.size(), h1, ir1_exp, ir1, ov1, occ1, od1, oc1);
    checkStage("skid0", sb0.size(), h0, ir0_exp, ir0, ov0, occ0, od0, oc0);
    e.data = d;
    e.ctrl = c;
    in1  = iv && ir1_exp && !fl && !fz;
    in0  = iv && ir0_exp && !fl && !fz;
    out1 = (sb1.size() > 0) && ordy && !fz;
    out0 = (sb0.size() > 0) && ordy && !fz;
    @(posedge clk);
    if (fl) sb1.delete();
    else begin
      if (out1) void'(sb1.pop_front());
      if (in1)  sb1.push_back(e);
    end
    if (fl) sb0.delete();
    else begin
      if (out0) void'(sb0.pop_front());
      if (in0)  sb0.push_back(e);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".s1.out_valid"}, ov1, 1'b0);
    checkOutput({tag, ".s1.occupancy"}, occ1, 2'd0);
    checkOutput({tag, ".s1.out_data"}, od1, '0);
    checkOutput({tag, ".s1.out_ctrl"}, oc1, BUB);
    checkOutput({tag, ".s0.out_valid"}, ov0, 1'b0);
    checkOutput({tag, ".s0.occupancy"}, occ0, 2'd0);
    checkOutput({tag, ".s0.out_data"}, od0, '0);
    checkOutput({tag, ".s0.out_ctrl"}, oc0, BUB);
  endtask

  initial begin
    @(negedge clk);
    #1;
    checkResetValues("reset");
    rst_n = 1'b1;

    // streaming
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, DW'(i), CW'(i + 16), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // backpressure
    applyStimulus(1'b1, 32'h11, 8'h01, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h22, 8'h02, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h33, 8'h03, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h33, 8'h03, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h33, 8'h03, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h33, 8'h03, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // flush with a full stage and a same-cycle input
    applyStimulus(1'b1, 32'h55, 8'h5A, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h66, 8'h5A, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h77, 8'h5A, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // freeze holds a live entry until released
    applyStimulus(1'b1, 32'h33, 8'h33, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h44, 8'h44, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // flush overrides freeze
    applyStimulus(1'b1, 32'h88, 8'h88, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h99, 8'h99, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // asynchronous reset in the middle of a stream
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(32'hA0 + i), CW'(i), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkResetValues("async_reset");
    sb1.delete();
    sb0.delete();
    #3;
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(32'hB0 + i), CW'(i + 1), 1'b1, 1'b0, 1'b0);

    // random traffic with occasional flush and freeze
    for (int i = 0; i < 80; i++)
      applyStimulus($urandom_range(0, 3) != 0, DW'($urandom), CW'($urandom),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 9) == 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
